// File: rtl/ahb_slv_pkg.sv
// Shared encodings, region map, FSM states and FIFO entry type for the AHB slave interface.
// AHB_SLV_ERR_EN adds the two-cycle ERROR response states.
package ahb_slv_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 3;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [ADDR_W-1:0] REG0_BASE  = 32'h8000_0000;
    localparam logic [ADDR_W-1:0] REG0_LIMIT = 32'h83FF_FFFF;
    localparam logic [ADDR_W-1:0] REG1_BASE  = 32'h8400_0000;
    localparam logic [ADDR_W-1:0] REG1_LIMIT = 32'h87FF_FFFF;
    localparam logic [ADDR_W-1:0] REG2_BASE  = 32'h8800_0000;
    localparam logic [ADDR_W-1:0] REG2_LIMIT = 32'h8BFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_RWAIT
`ifdef AHB_SLV_ERR_EN
        ,
        ST_ERR1,
        ST_ERR2
`endif
    } state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [SEL_W-1:0]  sel;
    } xfer_t;

    // One-hot region select; all-zero means out of range.
    function automatic logic [SEL_W-1:0] addr_decode(input logic [ADDR_W-1:0] addr);
        if (addr >= REG0_BASE && addr <= REG0_LIMIT) return 3'b001;
        if (addr >= REG1_BASE && addr <= REG1_LIMIT) return 3'b010;
        if (addr >= REG2_BASE && addr <= REG2_LIMIT) return 3'b100;
        return 3'b000;
    endfunction

endpackage

// File: rtl/ahb_slv_fifo.sv
// Two-entry synchronous FIFO carrying transfers from the AHB side to the APB side.
module ahb_slv_fifo
    import ahb_slv_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_push,
    input  xfer_t      i_push_data,
    input  logic       i_pop,
    output xfer_t      o_head,
    output logic [1:0] o_count
);

    xfer_t      r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;
    logic       w_do_push;
    logic       w_do_pop;

    assign w_do_pop  = i_pop && (r_count != 2'd0);
    assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + 2'(w_do_push) - 2'(w_do_pop);
        end
    end

    // Storage needs no reset: contents are only visible while count is non-zero.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/ahb_slave_if.sv
// AHB slave front end: decodes address phases and queues transfers for an APB bridge.
// AHB_SLV_ERR_EN enables ERROR responses for out-of-range accesses.
module ahb_slave_if
    import ahb_slv_pkg::*;
(
    input  logic              hclk,
    input  logic              hreset,
    input  logic              hwrite,
    input  logic              hreadyin,
    input  logic [1:0]        htrans,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [DATA_W-1:0] hwdata,
    output logic              hr_readyout,
    output logic [1:0]        hresp,
    output logic [DATA_W-1:0] hrdata,
    output logic              xfer_valid,
    input  logic              xfer_ready,
    output logic              xfer_write,
    output logic [ADDR_W-1:0] xfer_addr,
    output logic [DATA_W-1:0] xfer_wdata,
    output logic [SEL_W-1:0]  xfer_sel,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] prdata
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [SEL_W-1:0]  r_sel;
    logic              r_rd_pushed;
    logic              r_rd_done;
    logic [DATA_W-1:0] r_hrdata;

    logic              w_rd_pushed_nxt;
    logic              w_rd_done_nxt;
    logic [DATA_W-1:0] w_hrdata_nxt;
    logic              w_ready;
    logic [1:0]        w_hresp;
    logic              w_accept;
    logic              w_addr_valid;
    logic [SEL_W-1:0]  w_sel;
    logic              w_push;
    xfer_t             w_push_data;
    logic              w_pop;
    logic              w_space;
    logic [1:0]        w_count;
    xfer_t             w_head;

    ahb_slv_fifo u_fifo (
        .i_clk       (hclk),
        .i_rst       (hreset),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    assign xfer_valid = (w_count != 2'd0);
    assign w_pop      = xfer_valid && xfer_ready;
    assign w_space    = (w_count != 2'd2) || w_pop;
    assign w_sel      = addr_decode(haddr);

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_sel       <= '0;
            r_rd_pushed <= 1'b0;
            r_rd_done   <= 1'b0;
            r_hrdata    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rd_pushed <= w_rd_pushed_nxt;
            r_rd_done   <= w_rd_done_nxt;
            r_hrdata    <= w_hrdata_nxt;
            if (w_addr_valid) begin
                r_addr <= haddr;
                r_sel  <= w_sel;
            end
        end
    end

    // Data-phase handling first; w_accept marks states where a new address phase may start.
    always_comb begin
        w_state_nxt     = r_state;
        w_rd_pushed_nxt = r_rd_pushed;
        w_rd_done_nxt   = r_rd_done;
        w_hrdata_nxt    = r_hrdata;
        w_ready         = 1'b1;
        w_hresp         = HRESP_OKAY;
        w_accept        = 1'b0;
        w_addr_valid    = 1'b0;
        w_push          = 1'b0;
        w_push_data     = '0;

        case (r_state)
            ST_IDLE: w_accept = 1'b1;
            ST_WDATA: begin
                w_ready = w_space;
                if (w_space) begin
                    w_push            = 1'b1;
                    w_push_data.write = 1'b1;
                    w_push_data.addr  = r_addr;
                    w_push_data.wdata = hwdata;
                    w_push_data.sel   = r_sel;
                    w_state_nxt       = ST_IDLE;
                    w_accept          = 1'b1;
                end
            end
            ST_RWAIT: begin
                w_ready = r_rd_done;
                if (r_rd_done) begin
                    w_state_nxt     = ST_IDLE;
                    w_rd_pushed_nxt = 1'b0;
                    w_rd_done_nxt   = 1'b0;
                    w_accept        = 1'b1;
                end else if (!r_rd_pushed) begin
                    if (w_space) begin
                        w_push            = 1'b1;
                        w_push_data.write = 1'b0;
                        w_push_data.addr  = r_addr;
                        w_push_data.sel   = r_sel;
                        w_rd_pushed_nxt   = 1'b1;
                    end
                // The read is the newest entry, so an empty FIFO means it has been popped.
                end else if (w_count == 2'd0 && rd_valid) begin
                    w_hrdata_nxt  = prdata;
                    w_rd_done_nxt = 1'b1;
                end
            end
`ifdef AHB_SLV_ERR_EN
            ST_ERR1: begin
                w_ready     = 1'b0;
                w_hresp     = HRESP_ERROR;
                w_state_nxt = ST_ERR2;
            end
            ST_ERR2: begin
                w_hresp     = HRESP_ERROR;
                w_state_nxt = ST_IDLE;
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase

        w_addr_valid = w_accept && hreadyin && w_ready &&
                       (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);

        if (w_addr_valid) begin
            if (w_sel != 3'b000) begin
                w_state_nxt = hwrite ? ST_WDATA : ST_RWAIT;
            end else begin
`ifdef AHB_SLV_ERR_EN
                w_state_nxt = ST_ERR1;
`else
                w_state_nxt = ST_IDLE;
                if (!hwrite) w_hrdata_nxt = '0;
`endif
            end
        end
    end

    assign hr_readyout = w_ready;
    assign hresp       = w_hresp;
    assign hrdata      = r_hrdata;
    assign xfer_write  = w_head.write;
    assign xfer_addr   = w_head.addr;
    assign xfer_wdata  = w_head.wdata;
    assign xfer_sel    = w_head.sel;

endmodule

// File: tb/tb_ahb_slave_if.sv
// Directed bench for ahb_slave_if: single write/read, stalled burst, out-of-range and reset.
module tb_ahb_slave_if;

    logic        hclk;
    logic        hreset;
    logic        hwrite;
    logic        hreadyin;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hr_readyout;
    logic [1:0]  hresp;
    logic [31:0] hrdata;
    logic        xfer_valid;
    logic        xfer_ready;
    logic        xfer_write;
    logic [31:0] xfer_addr;
    logic [31:0] xfer_wdata;
    logic [2:0]  xfer_sel;
    logic        rd_valid;
    logic [31:0] prdata;

    int n_vec;
    int n_err;

    ahb_slave_if dut (
        .hclk        (hclk),
        .hreset      (hreset),
        .hwrite      (hwrite),
        .hreadyin    (hreadyin),
        .htrans      (htrans),
        .haddr       (haddr),
        .hwdata      (hwdata),
        .hr_readyout (hr_readyout),
        .hresp       (hresp),
        .hrdata      (hrdata),
        .xfer_valid  (xfer_valid),
        .xfer_ready  (xfer_ready),
        .xfer_write  (xfer_write),
        .xfer_addr   (xfer_addr),
        .xfer_wdata  (xfer_wdata),
        .xfer_sel    (xfer_sel),
        .rd_valid    (rd_valid),
        .prdata      (prdata)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; checks follow after one more unit.
    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic addr(input logic [1:0] t, input logic w, input logic [31:0] a);
        htrans = t;
        hwrite = w;
        haddr  = a;
    endtask

    task automatic chk_head(input string tag, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [2:0] s);
        chk({tag, "_valid"}, 32'(xfer_valid), 32'd1);
        chk({tag, "_write"}, 32'(xfer_write), 32'(w));
        chk({tag, "_addr"},  xfer_addr, a);
        chk({tag, "_wdata"}, xfer_wdata, d);
        chk({tag, "_sel"},   32'(xfer_sel), 32'(s));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        hreset = 1'b1; hreadyin = 1'b1; xfer_ready = 1'b0; rd_valid = 1'b0;
        prdata = '0; hwdata = '0;
        addr(2'b00, 1'b0, 32'h0);
        step(); step();
        hreset = 1'b0;
        #1;
        chk("rst_ready", 32'(hr_readyout), 32'd1);
        chk("rst_hresp", 32'(hresp), 32'd0);
        chk("rst_hrdata", hrdata, 32'd0);
        chk("rst_xvalid", 32'(xfer_valid), 32'd0);

        // BUSY and IDLE are ignored
        xfer_ready = 1'b1;
        addr(2'b01, 1'b1, 32'h8000_0000);
        step();
        addr(2'b00, 1'b1, 32'h8000_0000);
        #1;
        chk("busy_ready", 32'(hr_readyout), 32'd1);
        step(); #1;
        chk("busy_nopush", 32'(xfer_valid), 32'd0);

        // Single write, zero wait
        addr(2'b10, 1'b1, 32'h8000_0001);
        #1;
        chk("wr_aphase_ready", 32'(hr_readyout), 32'd1);
        step();
        addr(2'b00, 1'b0, 32'h0);
        hwdata = 32'h80;
        #1;
        chk("wr_dphase_ready", 32'(hr_readyout), 32'd1);
        step(); #1;
        chk_head("wr_head", 1'b1, 32'h8000_0001, 32'h80, 3'b001);
        step(); #1;
        chk("wr_drained", 32'(xfer_valid), 32'd0);

        // Single read; an early rd_valid while the entry is still queued is ignored
        addr(2'b10, 1'b0, 32'h8400_0010);
        step();
        addr(2'b00, 1'b0, 32'h0);
        #1;
        chk("rd_wait0", 32'(hr_readyout), 32'd0);
        step();
        rd_valid = 1'b1; prdata = 32'hDEAD;
        #1;
        chk_head("rd_head", 1'b0, 32'h8400_0010, 32'h0, 3'b010);
        chk("rd_wait1", 32'(hr_readyout), 32'd0);
        step();
        rd_valid = 1'b0; prdata = 32'h0;
        #1;
        chk("rd_early_ignored", hrdata, 32'h0);
        chk("rd_wait2", 32'(hr_readyout), 32'd0);
        step(); #1;
        chk("rd_wait3", 32'(hr_readyout), 32'd0);
        step();
        rd_valid = 1'b1; prdata = 32'hA5;
        #1;
        chk("rd_wait4", 32'(hr_readyout), 32'd0);
        step();
        rd_valid = 1'b0; prdata = 32'h0;
        #1;
        chk("rd_done_ready", 32'(hr_readyout), 32'd1);
        chk("rd_hrdata", hrdata, 32'hA5);
        step(); #1;
        chk("rd_idle_ready", 32'(hr_readyout), 32'd1);

        // INCR4 write burst with the APB side stalled
        xfer_ready = 1'b0;
        addr(2'b10, 1'b1, 32'h8000_0001);
        step();
        addr(2'b11, 1'b1, 32'h8000_0002); hwdata = 32'h11;
        #1;
        chk("b_d1_ready", 32'(hr_readyout), 32'd1);
        step();
        addr(2'b11, 1'b1, 32'h8000_0003); hwdata = 32'h22;
        #1;
        chk("b_d2_ready", 32'(hr_readyout), 32'd1);
        step();
        addr(2'b11, 1'b1, 32'h8000_0004); hwdata = 32'h33;
        #1;
        chk("b_d3_stall", 32'(hr_readyout), 32'd0);
        step(); #1;
        chk("b_d3_stall2", 32'(hr_readyout), 32'd0);
        xfer_ready = 1'b1;
        #1;
        chk("b_d3_release", 32'(hr_readyout), 32'd1);
        chk_head("b_h1", 1'b1, 32'h8000_0001, 32'h11, 3'b001);
        step();
        addr(2'b00, 1'b0, 32'h0); hwdata = 32'h44;
        #1;
        chk("b_d4_ready", 32'(hr_readyout), 32'd1);
        chk_head("b_h2", 1'b1, 32'h8000_0002, 32'h22, 3'b001);
        step(); #1;
        chk_head("b_h3", 1'b1, 32'h8000_0003, 32'h33, 3'b001);
        step(); #1;
        chk_head("b_h4", 1'b1, 32'h8000_0004, 32'h44, 3'b001);
        step(); #1;
        chk("b_drained", 32'(xfer_valid), 32'd0);

        // Upper edge of the third region
        addr(2'b10, 1'b1, 32'h8BFF_FFFF);
        step();
        addr(2'b00, 1'b0, 32'h0); hwdata = 32'h7;
        step(); #1;
        chk_head("top_edge", 1'b1, 32'h8BFF_FFFF, 32'h7, 3'b100);
        step();

        // Out-of-range write
        addr(2'b10, 1'b1, 32'h9000_0000);
        step();
        addr(2'b00, 1'b0, 32'h0); hwdata = 32'hBAD;
        #1;
`ifdef AHB_SLV_ERR_EN
        chk("oor_err1_hresp", 32'(hresp), 32'd1);
        chk("oor_err1_ready", 32'(hr_readyout), 32'd0);
        step(); #1;
        chk("oor_err2_hresp", 32'(hresp), 32'd1);
        chk("oor_err2_ready", 32'(hr_readyout), 32'd1);
        chk("oor_err2_xvalid", 32'(xfer_valid), 32'd0);
        step(); #1;
        chk("oor_after_hresp", 32'(hresp), 32'd0);
        chk("oor_after_xvalid", 32'(xfer_valid), 32'd0);
`else
        chk("oor_w_hresp", 32'(hresp), 32'd0);
        chk("oor_w_ready", 32'(hr_readyout), 32'd1);
        step(); #1;
        chk("oor_w_dropped", 32'(xfer_valid), 32'd0);
        // Out-of-range read just past the last region returns zero
        addr(2'b10, 1'b0, 32'h8C00_0000);
        step();
        addr(2'b00, 1'b0, 32'h0);
        #1;
        chk("oor_r_ready", 32'(hr_readyout), 32'd1);
        chk("oor_r_hresp", 32'(hresp), 32'd0);
        chk("oor_r_hrdata", hrdata, 32'h0);
        step(); #1;
        chk("oor_r_nopush", 32'(xfer_valid), 32'd0);
`endif

        // Reset with two queued writes and a pending read
        xfer_ready = 1'b0;
        addr(2'b10, 1'b1, 32'h8000_0010);
        step();
        addr(2'b10, 1'b1, 32'h8000_0014); hwdata = 32'h55;
        step();
        addr(2'b10, 1'b0, 32'h8400_0000); hwdata = 32'h66;
        step();
        addr(2'b00, 1'b0, 32'h0);
        #1;
        chk("prerst_ready", 32'(hr_readyout), 32'd0);
        chk("prerst_xvalid", 32'(xfer_valid), 32'd1);
        hreset = 1'b1;
        step();
        hreset = 1'b0;
        #1;
        chk("postrst_xvalid", 32'(xfer_valid), 32'd0);
        chk("postrst_ready", 32'(hr_readyout), 32'd1);
        chk("postrst_hresp", 32'(hresp), 32'd0);
        xfer_ready = 1'b1;
        rd_valid = 1'b1; prdata = 32'h99;
        step(); step();
        rd_valid = 1'b0;
        #1;
        chk("postrst_noxfer", 32'(xfer_valid), 32'd0);
        chk("postrst_hrdata", hrdata, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ahb_slave_if.md
AHB_SLAVE_IF -- requirements
Module: ahb_slave_if

Interface
REQ-001 SHALL have ports, clock and reset first, as follows:
- hclk  in  1  system clock; all state updates on rising edge
- hreset  in  1  synchronous, active-high reset
- hwrite  in  1  1=write, 0=read (address phase)
- hreadyin  in  1  bus ready; an address phase is sampled only when 1
- htrans  in  2  0=IDLE, 1=BUSY, 2=NONSEQ, 3=SEQ
- haddr  in  32  address
- hwdata  in  32  write data, valid in the data phase
- hr_readyout  out  1  0 stalls the current data phase
- hresp  out  2  00=OKAY, 01=ERROR
- hrdata  out  32  read data
- xfer_valid  out  1  head transfer available to the APB side
- xfer_ready  in  1  APB side consumes the head transfer
- xfer_write, xfer_addr[31:0], xfer_wdata[31:0], xfer_sel[2:0]  out  head transfer fields
- rd_valid  in  1  read completion strobe from the APB side
- prdata  in  32  read data, valid with rd_valid

Function
REQ-002 SHALL treat an address phase as valid when hreadyin=1, hr_readyout=1 and htrans is NONSEQ or SEQ; IDLE and BUSY SHALL be ignored with OKAY and zero wait.
REQ-003 SHALL decode the address to a select:
- 0x8000_0000-0x83FF_FFFF -> 001
- 0x8400_0000-0x87FF_FFFF -> 010
- 0x8800_0000-0x8BFF_FFFF -> 100
- any other address is out of range.
REQ-004 SHALL implement states IDLE, WDATA, RWAIT, ERR1 and ERR2.
REQ-005 SHALL transition on a valid address phase, from IDLE or WDATA: in-range write -> WDATA; in-range read -> RWAIT; out-of-range -> ERR1.
REQ-006 In WDATA, SHALL push {1, addr_q, hwdata, sel_q} into a 2-entry FIFO at the edge where count<2 or a pop occurs in the same cycle.
REQ-007 SHALL drive hr_readyout=0 while in WDATA with count=2 and no pop, and SHALL return to IDLE after the push if no new valid address phase is present.
REQ-008 In RWAIT, SHALL push the read entry {0, addr_q, 0, sel_q} once space exists.
REQ-009 SHALL hold hr_readyout=0 in RWAIT until rd_valid=1, which is honoured only after the read entry has been popped.
REQ-010 On an honoured rd_valid, SHALL register hrdata<=prdata, then in the next cycle drive hr_readyout=1 and return to IDLE.
REQ-011 ERR1 SHALL drive hresp=01 with hr_readyout=0; ERR2 SHALL drive hresp=01 with hr_readyout=1 and then go to IDLE.
REQ-012 ERR2 SHALL ignore any address phase presented, and nothing SHALL be pushed for an erroring transfer.
REQ-013 SHALL drive xfer_valid=!empty and pop on xfer_valid&xfer_ready.
REQ-014 On simultaneous push and pop, count SHALL be unchanged and FIFO order SHALL be preserved.
REQ-015 Writes and reads SHALL reach the APB side in bus order.
REQ-016 Back-to-back bursts (SEQ) SHALL sustain one transfer per cycle while the FIFO drains at one per cycle.

Reset
REQ-017 hreset=1 at a clock edge SHALL set: state=IDLE, FIFO count=0, pending read cleared, hr_readyout=1, hresp=00, hrdata=0, xfer_valid=0.
REQ-018 Reset mid-transfer SHALL discard FIFO contents and any outstanding read without emitting a partial transfer.

Configuration
REQ-019 With AHB_SLV_ERR_EN defined, out-of-range accesses SHALL follow REQ-011 and REQ-012.
REQ-020 Without AHB_SLV_ERR_EN, out-of-range accesses SHALL complete with OKAY and zero wait; reads SHALL return hrdata=0, writes SHALL be dropped, and ERR1/ERR2 SHALL be absent.

Structure
REQ-021 Package ahb_slv_pkg SHALL hold: htrans and hresp encodings, region base/limit constants, the state enum, and the FIFO entry struct.
REQ-022 The FIFO SHALL be sub-module ahb_slv_fifo: 2 entries, synchronous, with count output.

Verification
REQ-023 Single write to 0x8000_0001 with hwdata=0x80 and xfer_ready=1 -> one transfer {1, 0x8000_0001, 0x80, 001}, zero wait states.
REQ-024 Single read to 0x8400_0010 with rd_valid asserted 3 cycles after the pop and prdata=0xA5 -> hr_readyout low until then, hrdata=0xA5 with hr_readyout=1 one cycle later.
REQ-025 INCR4 write burst from 0x8000_0001 with xfer_ready=0 -> third data phase stalled (count=2); after xfer_ready=1, four transfers emitted in order at addresses 0x..01 to 0x..04.
REQ-026 Write to 0x9000_0000 -> hresp=01 for two cycles (hr_readyout 0 then 1), xfer_valid stays 0; with the macro undefined -> OKAY, zero wait, no transfer.
REQ-027 hreset asserted while the FIFO holds 2 entries and a read is pending -> next cycle xfer_valid=0, hr_readyout=1, hresp=00, state IDLE.
